// File: rtl/wb_ultrasonido_multi.sv
// Wishbone slave driving NCH HC-SR04 class rangers: hardware trigger pulse, echo width
// timing with timeout, latched per-channel results, status/irq, auto re-measure and a LED.
module wb_ultrasonido_multi #(
  parameter int NCH         = 4,
  parameter int TRIG_CYCLES = 500,
  parameter int TIMEOUT     = 135000,
  parameter int HOLDOFF     = 3000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wb_stb_i,
  input  logic           wb_cyc_i,
  input  logic           wb_we_i,
  input  logic [31:0]    wb_adr_i,
  input  logic [3:0]     wb_sel_i,
  input  logic [31:0]    wb_dat_i,
  output logic [31:0]    wb_dat_o,
  output logic           wb_ack_o,
  output logic [NCH-1:0] trig,
  input  logic [NCH-1:0] echo,
  output logic           led,
  output logic           irq
);

  // One counter serves both the trigger pulse and the echo timing, so size it for the longer.
  localparam int CMAX = (TIMEOUT > TRIG_CYCLES) ? TIMEOUT : TRIG_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(HOLDOFF + 1);

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_DONE
  } state_t;

  state_t        state_q  [NCH];
  state_t        state_d  [NCH];
  logic [CW-1:0] cnt_q    [NCH];
  logic [CW-1:0] cnt_d    [NCH];
  logic [CW-1:0] result_q [NCH];
  logic [CW-1:0] result_d [NCH];
  logic [HW-1:0] hold_q   [NCH];
  logic [HW-1:0] hold_d   [NCH];

  logic [NCH-1:0] pend_tmo_q, pend_tmo_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] tmo_q, tmo_d;
  logic [NCH-1:0] trig_q, trig_d;
  logic [NCH-1:0] sync_q, echo_q;
  logic [NCH-1:0] busy, start, set_done, set_tmo;

  logic        ack_q, ack_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        led_q, led_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata;

  logic       req, wr, rd;
  logic       ctrl_wr, status_wr, led_wr;
  logic [5:0] word;
  logic       unused_bits;

  // A request is accepted only when no ack is pending, so acks can never be back-to-back.
  assign req       = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr        = req & wb_we_i;
  assign rd        = req & ~wb_we_i;
  assign word      = wb_adr_i[7:2];
  assign ctrl_wr   = wr && (word == 6'd0);
  assign status_wr = wr && (word == 6'd1);
  assign led_wr    = wr && (word == 6'd2);

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      result_d[i]   = result_q[i];
      hold_d[i]     = '0;
      pend_tmo_d[i] = pend_tmo_q[i];
      set_done[i]   = 1'b0;
      set_tmo[i]    = 1'b0;
      busy[i]       = (state_q[i] != S_IDLE);
      start[i]      = (ctrl_wr && wb_dat_i[i]) ||
                      (auto_q && (state_q[i] == S_IDLE) && (hold_q[i] == HOLD_LAST));

      case (state_q[i])
        S_IDLE: begin
          if (start[i]) begin
            state_d[i]    = S_TRIG;
            cnt_d[i]      = '0;
            pend_tmo_d[i] = 1'b0;
          end else if (auto_q) begin
            hold_d[i] = hold_q[i] + HW'(1);
          end
        end
        S_TRIG: begin
          if (cnt_q[i] == TRIG_LAST) begin
            state_d[i] = S_WAIT;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_WAIT: begin
          if (echo_q[i]) begin
            state_d[i] = S_MEAS;
            cnt_d[i]   = CW'(1);
          end else if (cnt_q[i] == TMO_LAST) begin
            state_d[i]    = S_DONE;
            cnt_d[i]      = '0;
            pend_tmo_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_MEAS: begin
          // Saturate at TIMEOUT rather than counting past it.
          if (!echo_q[i]) begin
            state_d[i] = S_DONE;
          end else if (cnt_q[i] == TMO_MAX) begin
            state_d[i]    = S_DONE;
            pend_tmo_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_DONE: begin
          result_d[i] = cnt_q[i];
          set_done[i] = 1'b1;
          set_tmo[i]  = pend_tmo_q[i];
          cnt_d[i]    = '0;
          state_d[i]  = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase

      trig_d[i] = (state_d[i] == S_TRIG);
    end
  end

  always_comb begin
    ack_d  = req;
    auto_d = auto_q;
    ie_d   = ie_q;
    led_d  = led_q;
    done_d = done_q;
    tmo_d  = tmo_q;
    rdata  = '0;

    case (word)
      6'd0:    rdata = {22'd0, ie_q, auto_q, 8'd0};
      6'd1:    rdata = {8'd0, 8'(tmo_q), 8'(done_q), 8'(busy)};
      6'd2:    rdata = {31'd0, led_q};
      default: rdata = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (word == 6'(4 + i)) rdata = {{(32 - CW){1'b0}}, result_q[i]};
    end
    dat_d = rd ? rdata : 32'd0;

    if (ctrl_wr) begin
      auto_d = wb_dat_i[8];
      ie_d   = wb_dat_i[9];
    end
    if (led_wr) led_d = wb_dat_i[0];
    if (status_wr) begin
      done_d = done_d & ~wb_dat_i[8 +: NCH];
      tmo_d  = tmo_d & ~wb_dat_i[16 +: NCH];
    end
    for (int i = 0; i < NCH; i++) begin
      if (rd && (word == 6'(4 + i))) begin
        done_d[i] = 1'b0;
        tmo_d[i]  = 1'b0;
      end
    end
    // Completion wins over a clear landing in the same cycle.
    done_d = done_d | set_done;
    tmo_d  = tmo_d | set_tmo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= S_IDLE;
        cnt_q[i]    <= '0;
        result_q[i] <= '0;
        hold_q[i]   <= '0;
      end
      pend_tmo_q <= '0;
      done_q     <= '0;
      tmo_q      <= '0;
      trig_q     <= '0;
      sync_q     <= '0;
      echo_q     <= '0;
      ack_q      <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      led_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        result_q[i] <= result_d[i];
        hold_q[i]   <= hold_d[i];
      end
      pend_tmo_q <= pend_tmo_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      trig_q     <= trig_d;
      sync_q     <= echo;
      echo_q     <= sync_q;
      ack_q      <= ack_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      led_q      <= led_d;
      dat_q      <= dat_d;
    end
  end

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign wb_dat_o = dat_q;
  assign trig     = trig_q;
  assign led      = led_q;
  assign irq      = ie_q & |(done_q | tmo_q);

endmodule

// File: tb/tb_wb_ultrasonido_multi.sv
// Scoreboard bench for wb_ultrasonido_multi: bus reads queue their expected data, a monitor
// pops on every ack; trigger/irq/led behaviour is checked directly against hand-worked values.
module tb_wb_ultrasonido_multi;

  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0]    wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]     wb_sel_i;
  logic           wb_ack_o;
  logic [NCH-1:0] trig, echo;
  logic           led, irq;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  wb_ultrasonido_multi #(
    .NCH(NCH), .TRIG_CYCLES(4), .TIMEOUT(100), .HOLDOFF(50)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .trig(trig), .echo(echo), .led(led), .irq(irq)
  );

  // Monitor: every ack consumes one scoreboard entry; reads are compared, writes just consumed.
  always @(negedge clk) begin
    sb_t e;
    if (wb_ack_o) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_ack: got ack with dat_o=0x%08h, expected no ack", wb_dat_o);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) begin
          vectors++;
          if (wb_dat_o !== e.exp) begin
            miscompares++;
            $display("[TB] FAIL %s: dat_o=0x%08h expected 0x%08h", e.name, wb_dat_o, e.exp);
          end
        end
      end
    end
  end

  // One bus transaction; the expected read data goes to the scoreboard before the request.
  task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                               input logic chk, input logic [31:0] exp, input string name);
    sb_t e;
    e.chk  = chk;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {24'd0, adr};
    wb_dat_i = dat;
    @(posedge clk);
    @(negedge clk);
    #1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic busWrite(input logic [7:0] adr, input logic [31:0] dat);
    applyStimulus(1'b1, adr, dat, 1'b0, 32'd0, "write");
  endtask

  task automatic busRead(input logic [7:0] adr, input logic [31:0] exp, input string name);
    applyStimulus(1'b0, adr, 32'd0, 1'b1, exp, name);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Width of the next trigger pulse on channel ch, plus how many of those cycles the other channel was high.
  task automatic measureTrig(input int ch, output int width, output int other);
    int guard = 0;
    width = 0;
    other = 0;
    while (!trig[ch] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    while (trig[ch] && width < 50) begin
      width++;
      if (trig[1 - ch]) other++;
      @(negedge clk);
    end
  endtask

  task automatic pulseEcho(input int ch, input int cycles);
    @(negedge clk);
    echo[ch] = 1'b1;
    repeat (cycles) @(negedge clk);
    echo[ch] = 1'b0;
  endtask

  initial begin
    int w, o, hits;
    logic seen;

    reset    = 1'b1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = 4'hF;
    echo     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    checkOutput("rst_trig", 32'(trig), 32'd0);
    checkOutput("rst_led", 32'(led), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_dat", wb_dat_o, 32'd0);
    busRead(8'h00, 32'h0, "rst_ctrl");
    busRead(8'h04, 32'h0, "rst_status");
    busRead(8'h10, 32'h0, "rst_result0");
    busRead(8'h14, 32'h0, "rst_result1");
    busRead(8'h0C, 32'h0, "unmapped_0c");
    busRead(8'h40, 32'h0, "unmapped_40");

    // LED register holds bit 0 only
    busWrite(8'h08, 32'h1);
    checkOutput("led_on", 32'(led), 32'd1);
    busRead(8'h08, 32'h1, "led_read1");
    busWrite(8'h08, 32'h2);
    checkOutput("led_off", 32'(led), 32'd0);
    busRead(8'h08, 32'h0, "led_read0");

    // Single measurement of 37 cycles on channel 0
    busWrite(8'h00, 32'h1);
    measureTrig(0, w, o);
    checkOutput("t1_trig_width", 32'(w), 32'd4);
    checkOutput("t1_trig1_quiet", 32'(o), 32'd0);
    repeat (2) @(negedge clk);
    pulseEcho(0, 37);
    repeat (8) @(negedge clk);
    checkOutput("t1_irq_masked", 32'(irq), 32'd0);
    busRead(8'h04, 32'h0000_0100, "t1_status_done0");
    busRead(8'h10, 32'd37, "t1_result0");
    busRead(8'h04, 32'h0, "t1_status_cleared");

    // Echo never rises: timeout with zero result
    busWrite(8'h00, 32'h1);
    busRead(8'h04, 32'h0000_0001, "t2_busy0");
    repeat (120) @(negedge clk);
    busRead(8'h04, 32'h0001_0100, "t2_status_tmo0");
    busRead(8'h10, 32'd0, "t2_result0");
    busRead(8'h04, 32'h0, "t2_status_cleared");

    // Echo stuck high: result saturates at TIMEOUT
    busWrite(8'h00, 32'h1);
    measureTrig(0, w, o);
    repeat (2) @(negedge clk);
    pulseEcho(0, 500);
    repeat (6) @(negedge clk);
    busRead(8'h04, 32'h0001_0100, "t3_status_tmo0");
    busRead(8'h10, 32'd100, "t3_result0_sat");
    busRead(8'h04, 32'h0, "t3_status_cleared");

    // Both channels with AUTO and IE, widths 10 and 20
    busWrite(8'h00, 32'h303);
    measureTrig(0, w, o);
    checkOutput("t4_trig0_width", 32'(w), 32'd4);
    checkOutput("t4_trig1_together", 32'(o), 32'd4);
    repeat (2) @(negedge clk);
    echo = 2'b11;
    repeat (10) @(negedge clk);
    echo[0] = 1'b0;
    repeat (10) @(negedge clk);
    echo[1] = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("t4_irq_set", 32'(irq), 32'd1);
    busRead(8'h04, 32'h0000_0300, "t4_status_done");
    busRead(8'h00, 32'h0000_0300, "t4_ctrl_read");
    busRead(8'h10, 32'd10, "t4_result0");
    busWrite(8'h04, 32'h200);
    checkOutput("t4_irq_cleared", 32'(irq), 32'd0);
    busRead(8'h14, 32'd20, "t4_result1");

    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (trig[0]) seen = 1'b1;
    end
    checkOutput("t4_auto_retrigger", 32'(seen), 32'd1);
    busWrite(8'h00, 32'h0);
    repeat (250) @(negedge clk);
    busWrite(8'h04, 32'h00FF_FF00);
    busRead(8'h04, 32'h0, "t4_status_idle");
    hits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (trig != '0) hits++;
    end
    checkOutput("t4_no_trig_after_auto_off", 32'(hits), 32'd0);

    // Restart while busy is ignored; reset during MEAS clears everything
    busWrite(8'h08, 32'h1);
    busWrite(8'h00, 32'h1);
    fork
      measureTrig(0, w, o);
      busWrite(8'h00, 32'h1);
    join
    checkOutput("t5_trig_width_restart", 32'(w), 32'd4);
    repeat (2) @(negedge clk);
    echo[0] = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    echo[0] = 1'b0;
    reset   = 1'b0;
    checkOutput("t5_rst_trig", 32'(trig), 32'd0);
    checkOutput("t5_rst_led", 32'(led), 32'd0);
    checkOutput("t5_rst_irq", 32'(irq), 32'd0);
    checkOutput("t5_rst_ack", 32'(wb_ack_o), 32'd0);
    repeat (20) @(negedge clk);
    busRead(8'h04, 32'h0, "t5_status");
    busRead(8'h10, 32'h0, "t5_result0");
    busRead(8'h08, 32'h0, "t5_led_reg");

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_acks: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
